// File: rtl/ascii_word_assembler.sv
`default_nettype none
// ascii_word_assembler: packs ASCII '0'/'1' characters into a WIDTH-bit word with ready/valid output.
// Optional hex digit entry via ASCII_HEX_EN. Rev 1.0
module ascii_word_assembler #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_dv,
    input  logic [7:0]       rx_byte,
`ifdef ASCII_HEX_EN
    input  logic             hex_mode,
`endif
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [CW-1:0]    out_len,
    output logic             out_valid,
    output logic             err,
    output logic             ovf
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] next_sr;
    logic [CW-1:0]    next_cnt;
    logic             emit;
    logic             bad;
    logic             is_term;
    logic             is_space;
    logic             is_bin;
    logic             bin_mode;

    assign is_term  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
    assign is_space = (rx_byte == 8'h20);
    assign is_bin   = (rx_byte == 8'h30) || (rx_byte == 8'h31);

`ifdef ASCII_HEX_EN
    logic             is_hex;
    logic [3:0]       nib;
    logic [WIDTH-1:0] sr_hex;
    logic [CW:0]      cnt_plus4;

    assign bin_mode  = ~hex_mode;
    assign is_hex    = ((rx_byte >= 8'h30) && (rx_byte <= 8'h39)) ||
                       ((rx_byte >= 8'h41) && (rx_byte <= 8'h46)) ||
                       ((rx_byte >= 8'h61) && (rx_byte <= 8'h66));
    // Letters A-F / a-f both have low nibble 1..6, so +9 yields 10..15.
    assign nib       = (rx_byte <= 8'h39) ? rx_byte[3:0] : rx_byte[3:0] + 4'd9;
    assign cnt_plus4 = {1'b0, cnt} + (CW+1)'(4);

    if (WIDTH == 4) begin : g_hex_narrow
        assign sr_hex = nib;
    end else begin : g_hex_wide
        assign sr_hex = {sr[WIDTH-5:0], nib};
    end
`else
    assign bin_mode = 1'b1;
`endif

    always_comb begin
        next_sr  = sr;
        next_cnt = cnt;
        emit     = 1'b0;
        bad      = 1'b0;
        if (is_space) begin
            emit = 1'b0;
        end else if (is_term) begin
            emit = (cnt != '0);
        end else if (is_bin && bin_mode) begin
            next_sr  = {sr[WIDTH-2:0], rx_byte[0]};
            next_cnt = cnt + CW'(1);
            emit     = (next_cnt == CNT_FULL);
`ifdef ASCII_HEX_EN
        end else if (is_hex && hex_mode) begin
            if (cnt_plus4 > (CW+1)'(WIDTH)) begin
                bad = 1'b1;
            end else begin
                next_sr  = sr_hex;
                next_cnt = cnt_plus4[CW-1:0];
                emit     = (next_cnt == CNT_FULL);
            end
`endif
        end else begin
            bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= COLLECT;
            sr        <= '0;
            cnt       <= '0;
            out_word  <= '0;
            out_len   <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            err <= 1'b0;
            ovf <= 1'b0;
            if (state == FULL && out_ready) begin
                out_valid <= 1'b0;
                state     <= COLLECT;
            end
            // A strobe in the accepting cycle starts the next word (sr/cnt are already clear).
            if (state == FULL && !out_ready) begin
                if (rx_dv) ovf <= 1'b1;
            end else if (rx_dv) begin
                if (bad) begin
                    err <= 1'b1;
                    sr  <= '0;
                    cnt <= '0;
                end else if (emit) begin
                    out_word  <= next_sr;
                    out_len   <= next_cnt;
                    out_valid <= 1'b1;
                    state     <= FULL;
                    sr        <= '0;
                    cnt       <= '0;
                end else begin
                    sr  <= next_sr;
                    cnt <= next_cnt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascii_word_assembler.sv
`default_nettype none
// tb_ascii_word_assembler: table-driven vectors plus hand sequences for reset and hex corner cases.
module tb_ascii_word_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       hex_mode = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_word;
    logic [3:0] out_len;
    logic       out_valid;
    logic       err;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    ascii_word_assembler #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .rx_dv(rx_dv),
        .rx_byte(rx_byte),
`ifdef ASCII_HEX_EN
        .hex_mode(hex_mode),
`endif
        .out_ready(out_ready),
        .out_word(out_word),
        .out_len(out_len),
        .out_valid(out_valid),
        .err(err),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [7:0] ch;
        logic       rdy;
        logic       ev;
        logic [7:0] ew;
        logic [3:0] el;
        logic       ee;
        logic       eo;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic dv, input logic [7:0] ch, input logic rdy, input logic ev,
                       input logic [7:0] ew, input logic [3:0] el, input logic ee, input logic eo);
        vec_t v;
        v.dv = dv; v.ch = ch; v.rdy = rdy; v.ev = ev;
        v.ew = ew; v.el = el; v.ee = ee; v.eo = eo;
        vt.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, then compare registered outputs 1 time unit after the edge.
    task automatic step(input string nm, input logic dv, input logic [7:0] ch, input logic rdy,
                        input logic ev, input logic [7:0] ew, input logic [3:0] el,
                        input logic ee, input logic eo);
        rx_dv = dv; rx_byte = ch; out_ready = rdy;
        @(posedge clk);
        #1;
        rx_dv = 1'b0; rx_byte = 8'h00; out_ready = 1'b0;
        check({nm, ".valid"}, 32'(out_valid), 32'(ev));
        check({nm, ".err"},   32'(err),       32'(ee));
        check({nm, ".ovf"},   32'(ovf),       32'(eo));
        if (ev) begin
            check({nm, ".word"}, 32'(out_word), 32'(ew));
            check({nm, ".len"},  32'(out_len),  32'(el));
        end
    endtask

    initial begin
        //   dv    ch     rdy   ev    word   len   err   ovf
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h30, 1'b0, 1'b1, 8'hB2, 4'd8, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 4'd8, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h0D, 1'b0, 1'b1, 8'h05, 4'd3, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h0D, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h78, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h0A, 1'b0, 1'b1, 8'h03, 4'd2, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b1, 8'h03, 4'd2, 1'b0, 1'b1);
        add(1'b1, 8'h30, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h0D, 1'b0, 1'b1, 8'h01, 4'd2, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        add(1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

        #12;
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.word",  32'(out_word),  32'd0);
        check("reset.len",   32'(out_len),   32'd0);
        check("reset.err",   32'(err),       32'd0);
        check("reset.ovf",   32'(ovf),       32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            step($sformatf("vec%0d", i), vt[i].dv, vt[i].ch, vt[i].rdy,
                 vt[i].ev, vt[i].ew, vt[i].el, vt[i].ee, vt[i].eo);
        end

        // Reset mid-word: out_word still holds 0x01 from the last accepted word.
        step("mid1", 1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        step("mid2", 1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_mid.word", 32'(out_word), 32'd0);
        check("arst_mid.len",  32'(out_len),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 7; i++)
            step($sformatf("zero%0d", i), 1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        step("zero7", 1'b1, 8'h30, 1'b0, 1'b1, 8'h00, 4'd8, 1'b0, 1'b0);

        // Reset while a word is pending.
        #2;
        rst = 1'b0;
        #1;
        check("arst_full.valid", 32'(out_valid), 32'd0);
        check("arst_full.len",   32'(out_len),   32'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef ASCII_HEX_EN
        hex_mode = 1'b1;
        step("hex_a", 1'b1, 8'h61, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        step("hex_5", 1'b1, 8'h35, 1'b0, 1'b1, 8'hA5, 4'd8, 1'b0, 1'b0);
        step("hex_acc", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        hex_mode = 1'b0;
        step("mix_1", 1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        hex_mode = 1'b1;
        step("mix_F", 1'b1, 8'h46, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        step("mix_ovr", 1'b1, 8'h46, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        step("hex_x", 1'b1, 8'h67, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        step("hex_F1", 1'b1, 8'h46, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        step("hex_c2", 1'b1, 8'h63, 1'b0, 1'b1, 8'hFC, 4'd8, 1'b0, 1'b0);
        hex_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
